// File: rtl/eth_pkg.sv
// eth_pkg: constants, types and the CRC-32 byte step shared by the Ethernet
// transmit framer and the receive FCS checker.
//   ETH_PREAMBLE / ETH_SFD : preamble and start-of-frame delimiter bytes
//   CRC32_POLY             : IEEE 802.3 polynomial, normal (MSB-first) form
//   CRC32_INIT             : CRC register seed
//   CRC32_RESIDUE          : receiver residue over DA..FCS, normal bit order
//   tx_state_t             : transmit framer state
//   tx_beat_t              : one byte-time on the GMII-side transmit interface
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  typedef struct packed {
    logic       en;    // TX_EN
    logic       er;    // TX_ER
    logic [7:0] data;  // byte on the wire
  } tx_beat_t;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet shifts bits LSB first, so the register runs in reflected form
  // with the reversed polynomial.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  d);
    logic [31:0] c;
    logic [31:0] p;
    p = bit_rev32(CRC32_POLY);
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: byte-parallel reflected CRC-32, one byte per clock.
//   clk      in   clock
//   rst_n    in   async active-low reset, register returns to CRC32_INIT
//   init     in   reseed the register (wins over enable)
//   enable   in   fold data_in into the register this cycle
//   data_in  in   8  byte to fold
//   crc_out  out  32 current register value (not inverted)
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)        crc_d = CRC32_INIT;
    else if (enable) crc_d = crc32_byte(crc_q, data_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC32_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: transmit Ethernet framer feeding the RGMII ODDR stage.
// Wraps a payload byte stream with preamble, SFD, zero pad to MIN_FRAME,
// FCS and an IFG_BYTES idle gap. All wire-side outputs come straight from flops.
// Build option: define ETH_TX_FCS_EN to include the CRC engine and FCS append;
// without it the payload is expected to carry its own FCS.
//   clk_125m     in   byte clock
//   rst_n        in   async active-low reset
//   s_data       in   8  payload byte (DA first)
//   s_valid      in   s_data valid
//   s_last       in   final payload byte
//   s_ready      out  byte accepted this cycle (DATA state only)
//   tx_busy      out  frame or IFG in progress
//   tx_done      out  pulse with the final frame byte on the wire
//   tx_underrun  out  pulse with the abort byte on the wire
//   txd_rise     out  4  byte[3:0] for the rising edge
//   txd_fall     out  4  byte[7:4] for the falling edge
//   tx_ctl_rise  out  TX_EN
//   tx_ctl_fall  out  TX_EN ^ TX_ER
module rgmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       clk_125m,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun,
  output logic [3:0] txd_rise,
  output logic [3:0] txd_fall,
  output logic       tx_ctl_rise,
  output logic       tx_ctl_fall
);

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  // The state decides the byte that appears on the wire one cycle later, so
  // DATA is entered while the SFD is on the wire and payload follows it with
  // no bubble.
  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;   // DA..pad bytes sent
  logic [7:0]  aux_q, aux_d;            // preamble / FCS / IFG byte index
  tx_beat_t    beat_q, beat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        urun_q, urun_d;
  logic        body_end;                // last DA..pad byte decided this cycle

`ifdef ETH_TX_FCS_EN
  logic        crc_init, crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_val, fcs_word;

  // Reseed in every idle cycle so a frame always starts from the init value.
  assign crc_init = (state_q == IDLE);
  assign crc_en   = ((state_q == DATA) && s_valid) || (state_q == PAD);
  assign crc_data = (state_q == DATA) ? s_data : 8'h00;

  eth_crc32 u_crc (
    .clk     (clk_125m),
    .rst_n   (rst_n),
    .init    (crc_init),
    .enable  (crc_en),
    .data_in (crc_data),
    .crc_out (crc_val)
  );

  assign fcs_word = ~crc_val;
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
  assign s_ready = (state_q == DATA);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aux_d    = aux_q;
    beat_d   = '0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    urun_d   = 1'b0;
    body_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // s_data is only looked at; the first byte is consumed in DATA.
        if (s_valid) begin
          busy_d  = 1'b1;
          beat_d  = '{en: 1'b1, er: 1'b0, data: ETH_PREAMBLE};
          aux_d   = 8'd1;
          cnt_d   = '0;
          state_d = (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
        end
      end
      PREAMBLE: begin
        beat_d = '{en: 1'b1, er: 1'b0, data: ETH_PREAMBLE};
        aux_d  = aux_q + 8'd1;
        if (aux_q == PRE_LAST) state_d = SFD;
      end
      SFD: begin
        beat_d  = '{en: 1'b1, er: 1'b0, data: ETH_SFD};
        state_d = DATA;
      end
      DATA: begin
        if (s_valid) begin
          beat_d = '{en: 1'b1, er: 1'b0, data: s_data};
          cnt_d  = cnt_inc;
          if (s_last) begin
            if (cnt_inc < MIN_CNT) state_d = PAD;
            else                   body_end = 1'b1;
          end
        end else begin
          // Underrun: one error byte marks the frame bad, no FCS follows.
          beat_d  = '{en: 1'b1, er: 1'b1, data: 8'h00};
          urun_d  = 1'b1;
          aux_d   = '0;
          state_d = IFG;
        end
      end
      PAD: begin
        beat_d = '{en: 1'b1, er: 1'b0, data: 8'h00};
        cnt_d  = cnt_inc;
        if (cnt_inc >= MIN_CNT) body_end = 1'b1;
      end
      FCS: begin
`ifdef ETH_TX_FCS_EN
        beat_d = '{en: 1'b1, er: 1'b0, data: fcs_word[{aux_q[1:0], 3'b000} +: 8]};
        aux_d  = aux_q + 8'd1;
        if (aux_q[1:0] == 2'd3) begin
          done_d  = 1'b1;
          aux_d   = '0;
          state_d = IFG;
        end
`else
        state_d = IFG;
`endif
      end
      IFG: begin
        aux_d = aux_q + 8'd1;
        if (aux_q == IFG_LAST) begin
          aux_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (body_end) begin
      aux_d = '0;
`ifdef ETH_TX_FCS_EN
      state_d = FCS;
`else
      done_d  = 1'b1;
      state_d = IFG;
`endif
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aux_q   <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aux_q   <= aux_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign txd_rise    = beat_q.data[3:0];
  assign txd_fall    = beat_q.data[7:4];
  assign tx_ctl_rise = beat_q.en;
  assign tx_ctl_fall = beat_q.en ^ beat_q.er;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_underrun = urun_q;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Scoreboard bench for rgmii_tx_framer: the driver pushes the expected wire
// bytes of each frame into a queue; a negedge monitor pops one record per
// TX_EN cycle and checks idle cycles, IFG length, tx_busy tail and reset state.
module tb_rgmii_tx_framer;

  logic       clk_125m = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid, s_last;
  logic       s_ready, tx_busy, tx_done, tx_underrun;
  logic [3:0] txd_rise, txd_fall;
  logic       tx_ctl_rise, tx_ctl_fall;

  always #4 clk_125m = ~clk_125m;

  rgmii_tx_framer dut (
    .clk_125m    (clk_125m),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun),
    .txd_rise    (txd_rise),
    .txd_fall    (txd_fall),
    .tx_ctl_rise (tx_ctl_rise),
    .tx_ctl_fall (tx_ctl_fall)
  );

  typedef struct {
    logic [7:0] data;
    logic       er;
    logic       done;
    logic       urun;
    logic       body;   // DA..FCS byte, part of the receiver residue
    logic       first;  // first preamble byte
    logic       b2b;    // frame was queued during the previous IFG
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pl_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         prev_ok = 0;

  // Bit-serial reference CRC (LSB of each byte first).
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  task automatic build_expected(input int urun_at, input logic b2b);
    logic [7:0]  fr[$];
    logic [31:0] c;
    exp_t        r;
    for (int k = 0; k < 8; k++) begin
      r = '{data: (k == 7) ? 8'hD5 : 8'h55, er: 1'b0, done: 1'b0, urun: 1'b0,
            body: 1'b0, first: (k == 0), b2b: b2b};
      exp_q.push_back(r);
    end
    if (urun_at >= 0) begin
      for (int k = 0; k < urun_at; k++) begin
        r = '{data: pl_q[k], er: 1'b0, done: 1'b0, urun: 1'b0, body: 1'b1, first: 1'b0, b2b: 1'b0};
        exp_q.push_back(r);
      end
      r = '{data: 8'h00, er: 1'b1, done: 1'b0, urun: 1'b1, body: 1'b0, first: 1'b0, b2b: 1'b0};
      exp_q.push_back(r);
      return;
    end
    fr = pl_q;
    while (fr.size() < 60) fr.push_back(8'h00);
`ifdef ETH_TX_FCS_EN
    c = 32'hFFFFFFFF;
    foreach (fr[k]) c = crc_step(c, fr[k]);
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
`else
    c = 32'h0;
`endif
    foreach (fr[k]) begin
      r = '{data: fr[k], er: 1'b0, done: (k == fr.size() - 1), urun: 1'b0,
            body: 1'b1, first: 1'b0, b2b: 1'b0};
      exp_q.push_back(r);
    end
  endtask

  // gap: idle cycles with s_valid low before the frame (0 = queue during IFG).
  // urun_at / rst_at: payload index at which to stall or reset (-1 = never).
  task automatic send_frame(input int gap, input int urun_at, input int rst_at);
    int   n;
    int   wait_cyc;
    logic b2b;
    n   = pl_q.size();
    b2b = (gap == 0) && prev_ok;
    if (gap > 0) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (gap) @(posedge clk_125m);
      #1;
    end
    build_expected(urun_at, b2b);
    for (int i = 0; i < n; i++) begin
      if (i == urun_at) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk_125m);
        #1;
        prev_ok = 1'b1;
        return;
      end
      if (i == rst_at) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk_125m);
        #1 rst_n = 1'b1;
        prev_ok = 1'b0;
        return;
      end
      s_data  = pl_q[i];
      s_valid = 1'b1;
      s_last  = (i == n - 1);
      wait_cyc = 0;
      forever begin
        @(negedge clk_125m);
        if (s_ready) break;
        wait_cyc++;
        if (wait_cyc > 200) begin
          checks++;
          errors++;
          $display("FAIL ready_timeout: byte %0d got no s_ready in 200 cycles, want accept", i);
          s_valid = 1'b0;
          return;
        end
      end
      @(posedge clk_125m);
      #1;
    end
    prev_ok = 1'b1;
  endtask

  task automatic fill_rand(input int n);
    pl_q.delete();
    repeat (n) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- monitor ----------------
  exp_t        cur;
  int          idle_run = 0;
  int          busy_run = 0;
  bit          gap_valid = 0;
  bit          busy_trk = 0;
  bit          in_frame = 0;
  logic [31:0] racc = 32'hFFFFFFFF;

  always @(negedge clk_125m) begin
    if (!rst_n) begin
      checks++;
      if ({txd_rise, txd_fall, tx_ctl_rise, tx_ctl_fall, tx_busy, tx_done, tx_underrun} != 15'd0) begin
        errors++;
        $display("FAIL reset_outputs: got txd=%h%h ctl=%b%b busy=%b done=%b urun=%b, want all 0",
                 txd_fall, txd_rise, tx_ctl_rise, tx_ctl_fall, tx_busy, tx_done, tx_underrun);
      end
      gap_valid = 0;
      busy_trk  = 0;
      in_frame  = 0;
    end else if (tx_ctl_rise) begin
      busy_trk = 0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %h%h with TX_EN, want idle", txd_fall, txd_rise);
      end else begin
        cur = exp_q.pop_front();
        if (cur.first) begin
          in_frame = 1;
          racc     = 32'hFFFFFFFF;
          if (gap_valid) begin
            checks++;
            if (cur.b2b ? (idle_run != 12) : (idle_run < 12)) begin
              errors++;
              $display("FAIL ifg_gap: got %0d idle cycles, want %s12", idle_run, cur.b2b ? "" : ">=");
            end
          end
        end
        if ({txd_fall, txd_rise, tx_ctl_fall, tx_done, tx_underrun} !=
            {cur.data, ~cur.er, cur.done, cur.urun}) begin
          errors++;
          $display("FAIL tx_byte: got data=%h%h ctl_fall=%b done=%b urun=%b, want data=%h ctl_fall=%b done=%b urun=%b",
                   txd_fall, txd_rise, tx_ctl_fall, tx_done, tx_underrun,
                   cur.data, ~cur.er, cur.done, cur.urun);
        end
        if (cur.body) racc = crc_step(racc, {txd_fall, txd_rise});
        if (cur.done || cur.urun) begin
`ifdef ETH_TX_FCS_EN
          if (cur.done) begin
            checks++;
            if (rev32(racc) != 32'hC704DD7B) begin
              errors++;
              $display("FAIL fcs_residue: got %h, want c704dd7b", rev32(racc));
            end
          end
`endif
          in_frame  = 0;
          gap_valid = 1;
          idle_run  = 0;
          busy_trk  = 1;
          busy_run  = 0;
        end
      end
    end else begin
      checks++;
      if (in_frame || {txd_fall, txd_rise} != 8'h00 || tx_ctl_fall || tx_done || tx_underrun || s_ready) begin
        errors++;
        $display("FAIL idle_cycle: got in_frame=%b txd=%h%h ctl_fall=%b done=%b urun=%b ready=%b, want all 0",
                 in_frame, txd_fall, txd_rise, tx_ctl_fall, tx_done, tx_underrun, s_ready);
        in_frame = 0;
      end
      idle_run++;
      if (busy_trk) begin
        if (tx_busy) busy_run++;
        else begin
          checks++;
          if (busy_run != 12) begin
            errors++;
            $display("FAIL busy_tail: got %0d busy idle cycles, want 12", busy_run);
          end
          busy_trk = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len, gap, ur, budget;
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_125m);
    #1 rst_n = 1'b1;

    // Short frame: pads to minimum length.
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(3, -1, -1);
    // Minimum-length and over-minimum payloads, queued back to back.
    fill_rand(64); send_frame(0, -1, -1);
    fill_rand(60); send_frame(0, -1, -1);
    fill_rand(59); send_frame(0, -1, -1);
    // Underrun after 10 bytes, then back-to-back pair.
    fill_rand(20); send_frame(0, 10, -1);
    fill_rand(61); send_frame(0, -1, -1);
    fill_rand(5);  send_frame(0, -1, -1);
    // 1-byte frame pads 59.
    fill_rand(1);  send_frame(5, -1, -1);
    // Reset in the middle of DATA, then the same frame again.
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(2, -1, 2);
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(0, -1, -1);

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 80);
      gap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
      ur  = (len >= 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1;
      fill_rand(len);
      send_frame(gap, ur, -1);
    end

    s_valid = 1'b0;
    s_last  = 1'b0;
    budget  = 0;
    while ((exp_q.size() != 0 || tx_busy) && budget < 3000) begin
      @(posedge clk_125m);
      budget++;
    end
    repeat (3) @(negedge clk_125m);
    checks++;
    if (exp_q.size() != 0 || tx_busy) begin
      errors++;
      $display("FAIL drain: got %0d bytes pending busy=%b, want 0 pending and idle", exp_q.size(), tx_busy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
